// File: rtl/tl_ul_mem_responder_pkg.sv
// Shared TileLink-UL opcodes and the response-queue entry type for the memory responder.
// Entry fields are sized for the widest supported bus; narrower instances zero-extend.
package tl_pkg;

  localparam logic [2:0] TL_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_GET        = 3'd4;
  localparam logic [2:0] TL_ACK        = 3'd0;
  localparam logic [2:0] TL_ACKDATA    = 3'd1;

  // Upper bounds on DATA_W, SRC_W and RESP_LAT-1 that a queue entry can carry.
  localparam int TL_DATA_W_MAX = 64;
  localparam int TL_SRC_W_MAX  = 8;
  localparam int TL_CNT_W      = 8;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [2:0]               size;
    logic [TL_SRC_W_MAX-1:0]  source;
    logic                     denied;
    logic [TL_DATA_W_MAX-1:0] data;
    logic [TL_CNT_W-1:0]      cnt;
  } tl_resp_t;

  function automatic logic tl_is_put(input logic [2:0] op);
    return (op == TL_PUTFULL) || (op == TL_PUTPARTIAL);
  endfunction

endpackage

// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel bundle between a requester (master) and the memory responder (slave).
// valid/ready: a beat transfers on a rising edge where both are high; the sender holds the payload stable while valid && !ready.
interface tl_ul_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 3,
  parameter int SINK_W = 2
);

  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_W-1:0]      a_source;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W/8-1:0]   a_mask;
  logic [DATA_W-1:0]     a_data;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [2:0]            d_size;
  logic [SRC_W-1:0]      d_source;
  logic [SINK_W-1:0]     d_sink;
  logic                  d_denied;
  logic [DATA_W-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

endinterface

// File: rtl/tl_ul_mem_responder_resp_queue.sv
// Circular FIFO of pending D responses; every entry counts down its remaining latency
// and the head is presentable once its count reaches zero.
module tl_resp_queue
  import tl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  tl_resp_t                     push_data,
  input  logic                         pop,
  output tl_resp_t                     head,
  output logic                         head_ready,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  tl_resp_t         entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign head       = entries[rd_ptr];
  assign head_ready = !empty && (head.cnt == '0);

  // A freshly pushed entry overrides the slot's countdown in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].cnt != '0) begin
          entries[i].cnt <= entries[i].cnt - 1'b1;
        end
      end
      if (push_ok) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL slave memory model: decodes A requests, updates a byte-lane memory and
// returns AccessAck/AccessAckData on D after a fixed minimum latency, in acceptance order.
module tl_ul_mem_responder
  import tl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                SRC_W     = 3,
  parameter int                SINK_W    = 2,
  parameter int                MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RESP_LAT  = 2,
  parameter int                QDEPTH    = 2
) (
  input  logic     clock,
  input  logic     reset,
  tl_ul_if.slave   tl
);

  localparam int                STRB_W    = DATA_W / 8;
  localparam int                LANE_BITS = $clog2(STRB_W);
  localparam int                IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * STRB_W);
  localparam logic [2:0]        SIZE_MAX  = 3'(LANE_BITS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [ADDR_W-1:0]            offset;
  logic [ADDR_W-1:0]            align_mask;
  logic [IDX_W-1:0]             word_idx;
  logic                         is_get;
  logic                         is_put;
  logic                         op_ok;
  logic                         size_ok;
  logic                         in_range;
  logic                         aligned;
  logic                         denied;
  logic                         a_ready_int;
  logic                         a_fire;
  logic                         mem_we;

  tl_resp_t                     push_entry;
  tl_resp_t                     head;
  logic                         head_ready;
  logic                         q_full;
  logic                         q_empty;
  logic [$clog2(QDEPTH+1)-1:0]  q_count;
  logic                         unused_ok;

  // Request decode; the offset subtraction avoids overflow of BASE_ADDR + size.
  assign offset     = tl.a_address - BASE_ADDR;
  assign word_idx   = offset[LANE_BITS +: IDX_W];
  assign is_get     = (tl.a_opcode == TL_GET);
  assign is_put     = tl_is_put(tl.a_opcode);
  assign op_ok      = is_get || is_put;
  assign size_ok    = (tl.a_size <= SIZE_MAX);
  assign in_range   = (tl.a_address >= BASE_ADDR) && (offset < MEM_BYTES);
  assign align_mask = (ADDR_W'(1) << tl.a_size) - ADDR_W'(1);
  assign aligned    = ((tl.a_address & align_mask) == '0);
  assign denied     = !op_ok || !size_ok || !in_range || !aligned;

  // a_ready depends only on reset and stored occupancy, never on d_ready.
  assign a_ready_int = !reset && !q_full;
  assign tl.a_ready  = a_ready_int;
  assign a_fire      = tl.a_valid && a_ready_int;
  assign mem_we      = a_fire && is_put && !denied;

  // Backing store is deliberately left out of reset so contents survive a harness reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (tl.a_mask[b]) begin
          mem[word_idx][b*8 +: 8] <= tl.a_data[b*8 +: 8];
        end
      end
    end
  end

  // Read data is captured from the pre-edge array, so a same-cycle write is not visible.
  always_comb begin
    push_entry                      = '0;
    push_entry.opcode               = is_get ? TL_ACKDATA : TL_ACK;
    push_entry.size                 = tl.a_size;
    push_entry.source[SRC_W-1:0]    = tl.a_source;
    push_entry.denied               = denied;
    push_entry.cnt                  = TL_CNT_W'(RESP_LAT - 1);
    if (is_get && !denied) begin
      push_entry.data[DATA_W-1:0] = mem[word_idx];
    end
  end

  tl_resp_queue #(
    .DEPTH (QDEPTH)
  ) u_resp_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (a_fire),
    .push_data  (push_entry),
    .pop        (head_ready && tl.d_ready),
    .head       (head),
    .head_ready (head_ready),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  // D payload is forced to zero whenever no response is being presented.
  always_comb begin
    tl.d_valid  = head_ready;
    tl.d_opcode = '0;
    tl.d_param  = '0;
    tl.d_size   = '0;
    tl.d_source = '0;
    tl.d_sink   = '0;
    tl.d_denied = 1'b0;
    tl.d_data   = '0;
    if (head_ready) begin
      tl.d_opcode = head.opcode;
      tl.d_size   = head.size;
      tl.d_source = head.source[SRC_W-1:0];
      tl.d_denied = head.denied;
      tl.d_data   = head.data[DATA_W-1:0];
    end
  end

  assign unused_ok = ^{tl.a_param, offset, head, q_empty, q_count};

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Directed bench for tl_ul_mem_responder: drivers push expected D beats into a queue,
// a negedge monitor pops and compares every D fire.
module tb_tl_ul_mem_responder;
  import tl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 3;
  localparam int SINK_W = 2;
  localparam int RESP_W = 3 + 2 + 3 + SRC_W + SINK_W + 1 + DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  logic [RESP_W-1:0] exp_q[$];
  string             name_q[$];
  logic [RESP_W-1:0] mon_got;
  logic [RESP_W-1:0] mon_want;
  string             mon_name;

  tl_ul_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SINK_W(SINK_W)) bus ();

  tl_ul_mem_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SRC_W     (SRC_W),
    .SINK_W    (SINK_W),
    .MEM_WORDS (256),
    .BASE_ADDR (32'h8000_0000),
    .RESP_LAT  (2),
    .QDEPTH    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tl    (bus)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [RESP_W-1:0] pack_resp(input logic [2:0] op, input logic [2:0] size,
                                                  input logic [SRC_W-1:0] src, input logic denied,
                                                  input logic [DATA_W-1:0] data);
    return {op, 2'b00, size, src, {SINK_W{1'b0}}, denied, data};
  endfunction

  function automatic logic [RESP_W-1:0] d_bus();
    return {bus.d_opcode, bus.d_param, bus.d_size, bus.d_source, bus.d_sink, bus.d_denied, bus.d_data};
  endfunction

  task automatic check_bit(input string nm, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic check_word(input string nm, input logic [RESP_W-1:0] got, input logic [RESP_W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && bus.d_valid && bus.d_ready) begin
      mon_got = d_bus();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got %h want none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_got !== mon_want) begin
          miscompares++;
          $display("FAIL %s: got %h want %h", mon_name, mon_got, mon_want);
        end
      end
    end
  end

  // Driver: call just after a rising edge; returns just after the edge where A fired.
  task automatic send(input string nm, input logic [2:0] op, input logic [31:0] addr,
                      input logic [2:0] size, input logic [SRC_W-1:0] src, input logic [7:0] mask,
                      input logic [63:0] data, input logic [RESP_W-1:0] exp_resp);
    int waited;
    waited        = 0;
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = 3'd0;
    bus.a_size    = size;
    bus.a_source  = src;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    @(negedge clock);
    while (!bus.a_ready && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.a_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_accept: got a_ready=0 want a_ready=1 within 64 cycles", nm);
    end else begin
      exp_q.push_back(exp_resp);
      name_q.push_back(nm);
    end
    @(posedge clock);
    #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int stale;
    bus.a_valid   = 1'b0;
    bus.a_opcode  = '0;
    bus.a_param   = '0;
    bus.a_size    = '0;
    bus.a_source  = '0;
    bus.a_address = '0;
    bus.a_mask    = '0;
    bus.a_data    = '0;
    bus.d_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_bit("rst_a_ready", bus.a_ready, 1'b0);
    check_bit("rst_d_valid", bus.d_valid, 1'b0);
    check_word("rst_d_fields", d_bus(), '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_bit("post_rst_a_ready", bus.a_ready, 1'b1);
    @(posedge clock);
    #1;

    // Put then Get, with latency check on the AccessAck
    send("put_full", TL_PUTFULL, 32'h8000_0008, 3'd3, 3'd1, 8'hFF, 64'h1122_3344_5566_7788,
         pack_resp(TL_ACK, 3'd3, 3'd1, 1'b0, 64'h0));
    @(negedge clock);
    check_bit("lat_cycle1_d_valid", bus.d_valid, 1'b0);
    @(negedge clock);
    check_bit("lat_cycle2_d_valid", bus.d_valid, 1'b1);
    @(posedge clock);
    #1;
    send("get_full", TL_GET, 32'h8000_0008, 3'd3, 3'd2, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd2, 1'b0, 64'h1122_3344_5566_7788));
    drain();

    // Partial write, Get issued the very next cycle
    send("put_partial", TL_PUTPARTIAL, 32'h8000_0008, 3'd3, 3'd2, 8'h0F, 64'hFFFF_FFFF_AAAA_AAAA,
         pack_resp(TL_ACK, 3'd3, 3'd2, 1'b0, 64'h0));
    send("get_partial", TL_GET, 32'h8000_0008, 3'd3, 3'd3, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd3, 1'b0, 64'h1122_3344_AAAA_AAAA));
    drain();

    // Denials, denied Puts, and the last mapped word
    send("deny_range", TL_GET, 32'h0000_1000, 3'd3, 3'd0, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd0, 1'b1, 64'h0));
    send("deny_opcode", 3'd6, 32'h8000_0008, 3'd3, 3'd1, 8'h00, 64'h0,
         pack_resp(TL_ACK, 3'd3, 3'd1, 1'b1, 64'h0));
    send("deny_size", TL_GET, 32'h8000_0000, 3'd4, 3'd2, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd4, 3'd2, 1'b1, 64'h0));
    send("deny_align", TL_GET, 32'h8000_0004, 3'd3, 3'd3, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd3, 1'b1, 64'h0));
    send("deny_put_align", TL_PUTFULL, 32'h8000_000C, 3'd3, 3'd4, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
         pack_resp(TL_ACK, 3'd3, 3'd4, 1'b1, 64'h0));
    send("deny_put_range", TL_PUTFULL, 32'h8000_0800, 3'd3, 3'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
         pack_resp(TL_ACK, 3'd3, 3'd5, 1'b1, 64'h0));
    send("put_last_word", TL_PUTFULL, 32'h8000_07F8, 3'd3, 3'd6, 8'hFF, 64'h0BAD_F00D_600D_CAFE,
         pack_resp(TL_ACK, 3'd3, 3'd6, 1'b0, 64'h0));
    send("get_after_deny", TL_GET, 32'h8000_0008, 3'd3, 3'd7, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd7, 1'b0, 64'h1122_3344_AAAA_AAAA));
    send("get_last_word", TL_GET, 32'h8000_07F8, 3'd3, 3'd0, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd0, 1'b0, 64'h0BAD_F00D_600D_CAFE));
    drain();

    // Backpressure and full queue
    send("put_w2", TL_PUTFULL, 32'h8000_0010, 3'd3, 3'd1, 8'hFF, 64'hDEAD_BEEF_0123_4567,
         pack_resp(TL_ACK, 3'd3, 3'd1, 1'b0, 64'h0));
    drain();
    bus.d_ready = 1'b0;
    send("bp_get1", TL_GET, 32'h8000_0008, 3'd3, 3'd4, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd4, 1'b0, 64'h1122_3344_AAAA_AAAA));
    send("bp_get2", TL_GET, 32'h8000_0010, 3'd3, 3'd5, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd5, 1'b0, 64'hDEAD_BEEF_0123_4567));
    @(negedge clock);
    check_bit("full_a_ready", bus.a_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_bit("bp_hold_valid", bus.d_valid, 1'b1);
      check_word("bp_hold_fields", d_bus(), pack_resp(TL_ACKDATA, 3'd3, 3'd4, 1'b0, 64'h1122_3344_AAAA_AAAA));
    end
    @(posedge clock);
    #1;
    bus.d_ready = 1'b1;
    fork
      send("bp_get3", TL_GET, 32'h8000_07F8, 3'd3, 3'd6, 8'h00, 64'h0,
           pack_resp(TL_ACKDATA, 3'd3, 3'd6, 1'b0, 64'h0BAD_F00D_600D_CAFE));
    join_none
    @(negedge clock);
    check_bit("full_closed_on_d_fire", bus.a_ready, 1'b0);
    @(negedge clock);
    check_bit("a_ready_reopen", bus.a_ready, 1'b1);
    drain();

    // Reset mid-flight
    send("put_w3", TL_PUTFULL, 32'h8000_0018, 3'd3, 3'd2, 8'hFF, 64'hCAFE_F00D_1234_5678,
         pack_resp(TL_ACK, 3'd3, 3'd2, 1'b0, 64'h0));
    drain();
    bus.d_ready = 1'b0;
    send("rst_get_a", TL_GET, 32'h8000_0008, 3'd3, 3'd1, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd1, 1'b0, 64'h1122_3344_AAAA_AAAA));
    send("rst_get_b", TL_GET, 32'h8000_0018, 3'd3, 3'd2, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd2, 1'b0, 64'hCAFE_F00D_1234_5678));
    #1;
    check_bit("pre_rst_d_valid", bus.d_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_bit("async_rst_d_valid", bus.d_valid, 1'b0);
    check_bit("async_rst_a_ready", bus.a_ready, 1'b0);
    check_word("async_rst_d_fields", d_bus(), '0);
    exp_q.delete();
    name_q.delete();
    bus.d_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.d_valid) stale++;
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL stale_after_reset: got %0d valid cycles want 0", stale);
    end
    @(posedge clock);
    #1;
    send("mem_keep_w3", TL_GET, 32'h8000_0018, 3'd3, 3'd3, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd3, 1'b0, 64'hCAFE_F00D_1234_5678));
    send("mem_keep_w1", TL_GET, 32'h8000_0008, 3'd3, 3'd4, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd4, 1'b0, 64'h1122_3344_AAAA_AAAA));
    drain();

    // Source and size echo
    send("echo_src3", TL_GET, 32'h8000_0008, 3'd3, 3'd3, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd3, 3'd3, 1'b0, 64'h1122_3344_AAAA_AAAA));
    send("echo_src5", TL_GET, 32'h8000_000C, 3'd2, 3'd5, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd2, 3'd5, 1'b0, 64'h1122_3344_AAAA_AAAA));
    send("echo_src7", TL_GET, 32'h8000_000A, 3'd1, 3'd7, 8'h00, 64'h0,
         pack_resp(TL_ACKDATA, 3'd1, 3'd7, 1'b0, 64'h1122_3344_AAAA_AAAA));
    drain();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
